// File: rtl/bus_sync_fifo.sv
// Destination-side bus synchroniser: qualifies a source-domain enable through a flop chain,
// captures the crossed bus once per detected event and buffers it in a small valid/ready FIFO.
module bus_sync_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                     dest_clk,
    input  logic                     dest_rst,
    input  logic [DATA_WIDTH-1:0]    unsync_bus,
    input  logic                     bus_enable,
    output logic [DATA_WIDTH-1:0]    sync_bus,
    output logic                     sync_valid,
    input  logic                     sync_ready,
    output logic                     enable_pulse_d,
    output logic                     ack_toggle,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;
    logic                   sync_last;
    logic                   det_event;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], bus_enable};
            sync_d <= sync_last;
        end
    end

    assign sync_last = sync[SYNC_STAGES-1];

    generate
        if (TOGGLE_MODE != 0) begin : g_toggle
            assign det_event = sync_last ^ sync_d;
        end else begin : g_level
            assign det_event = sync_last & ~sync_d;
        end
    endgenerate

    // A pop on the capture edge frees the slot the new word needs, so full+pop still accepts.
    assign sync_valid = (count != '0);
    assign full       = (count == FULL_CNT);
    assign pop        = sync_valid & sync_ready;
    assign push       = det_event & (~full | pop);
    assign drop       = det_event & full & ~pop;

    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            enable_pulse_d <= 1'b0;
            ack_toggle     <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            enable_pulse_d <= det_event;
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                ack_toggle <= ~ack_toggle;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is reset so the head reads zero after reset.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= unsync_bus;
        end
    end

    assign sync_bus = mem[rd_ptr];

endmodule

// File: tb/tb_bus_sync_fifo.sv
// Directed and randomised checks for bus_sync_fifo across three parameter sets
// (default, toggle mode with three sync stages, and a 16-bit four-deep variant).
module tb_bus_sync_fifo;

    logic dest_clk = 1'b0;
    logic dest_rst = 1'b0;

    always #5 dest_clk = ~dest_clk;

    // Instance A: default parameters
    logic [7:0] a_unsync = '0, a_bus;
    logic       a_en = 1'b0, a_valid, a_ready = 1'b0, a_pulse, a_ack, a_ovf, a_clr = 1'b0;
    logic [1:0] a_count;

    // Instance B: toggle mode, three sync stages
    logic [7:0] b_unsync = '0, b_bus;
    logic       b_en = 1'b0, b_valid, b_ready = 1'b0, b_pulse, b_ack, b_ovf, b_clr = 1'b0;
    logic [1:0] b_count;

    // Instance C: 16-bit, four deep
    logic [15:0] c_unsync = '0, c_bus;
    logic        c_en = 1'b0, c_valid, c_ready = 1'b0, c_pulse, c_ack, c_ovf, c_clr = 1'b0;
    logic [2:0]  c_count;

    int errors = 0;
    int checks = 0;
    logic a_ack_exp = 1'b0;

    bus_sync_fifo u_a (
        .dest_clk(dest_clk), .dest_rst(dest_rst), .unsync_bus(a_unsync), .bus_enable(a_en),
        .sync_bus(a_bus), .sync_valid(a_valid), .sync_ready(a_ready), .enable_pulse_d(a_pulse),
        .ack_toggle(a_ack), .overflow(a_ovf), .clr_overflow(a_clr), .count(a_count)
    );

    bus_sync_fifo #(.DATA_WIDTH(8), .SYNC_STAGES(3), .DEPTH(2), .TOGGLE_MODE(1)) u_b (
        .dest_clk(dest_clk), .dest_rst(dest_rst), .unsync_bus(b_unsync), .bus_enable(b_en),
        .sync_bus(b_bus), .sync_valid(b_valid), .sync_ready(b_ready), .enable_pulse_d(b_pulse),
        .ack_toggle(b_ack), .overflow(b_ovf), .clr_overflow(b_clr), .count(b_count)
    );

    bus_sync_fifo #(.DATA_WIDTH(16), .SYNC_STAGES(2), .DEPTH(4), .TOGGLE_MODE(0)) u_c (
        .dest_clk(dest_clk), .dest_rst(dest_rst), .unsync_bus(c_unsync), .bus_enable(c_en),
        .sync_bus(c_bus), .sync_valid(c_valid), .sync_ready(c_ready), .enable_pulse_d(c_pulse),
        .ack_toggle(c_ack), .overflow(c_ovf), .clr_overflow(c_clr), .count(c_count)
    );

    task automatic step();
        @(posedge dest_clk);
        #1;
    endtask

    // Level-mode event on A: enable high for three samples, then low for three.
    task automatic a_push(input logic [7:0] d);
        a_unsync = d;
        a_en = 1'b1;
        step(); step(); step();
        a_en = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset();
        #1 dest_rst = 1'b1;
        #2;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
        checks++; if (a_bus !== 8'h00) begin errors++; $display("FAIL reset_a_bus got=%h exp=00", a_bus); end
        checks++; if (a_pulse !== 1'b0) begin errors++; $display("FAIL reset_a_pulse got=%b exp=0", a_pulse); end
        checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_a_ack got=%b exp=0", a_ack); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_a_ovf got=%b exp=0", a_ovf); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
        checks++; if (c_count !== 3'd0) begin errors++; $display("FAIL reset_c_count got=%0d exp=0", c_count); end
        step(); step();
        dest_rst = 1'b0;
        step();
    endtask

    task automatic test_single_capture();
        int pulses;
        a_unsync = 8'hA5;
        a_en = 1'b1;
        step(); // E0
        checks++; if (a_pulse !== 1'b0) begin errors++; $display("FAIL single_e0_pulse got=%b exp=0", a_pulse); end
        step(); // E1
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_e1_valid got=%b exp=0", a_valid); end
        step(); // E2: capture
        a_ack_exp = ~a_ack_exp;
        checks++; if (a_pulse !== 1'b1) begin errors++; $display("FAIL single_e2_pulse got=%b exp=1", a_pulse); end
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", a_valid); end
        checks++; if (a_bus !== 8'hA5) begin errors++; $display("FAIL single_bus got=%h exp=a5", a_bus); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", a_count); end
        checks++; if (a_ack !== a_ack_exp) begin errors++; $display("FAIL single_ack got=%b exp=%b", a_ack, a_ack_exp); end
        a_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL single_extra_pulses got=%0d exp=0", pulses); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL single_count_hold got=%0d exp=1", a_count); end
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", a_valid); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", a_count); end
    endtask

    task automatic test_overflow();
        a_push(8'h11);
        a_ack_exp = ~a_ack_exp;
        checks++; if (a_ack !== a_ack_exp) begin errors++; $display("FAIL ovf_ack1 got=%b exp=%b", a_ack, a_ack_exp); end
        a_push(8'h22);
        a_ack_exp = ~a_ack_exp;
        checks++; if (a_ack !== a_ack_exp) begin errors++; $display("FAIL ovf_ack2 got=%b exp=%b", a_ack, a_ack_exp); end
        a_push(8'h33);
        checks++; if (a_ack !== a_ack_exp) begin errors++; $display("FAIL ovf_ack_drop got=%b exp=%b", a_ack, a_ack_exp); end
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", a_count); end
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", a_ovf); end
        checks++; if (a_bus !== 8'h11) begin errors++; $display("FAIL ovf_head0 got=%h exp=11", a_bus); end
        a_ready = 1'b1;
        step();
        checks++; if (a_bus !== 8'h22) begin errors++; $display("FAIL ovf_head1 got=%h exp=22", a_bus); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL ovf_count1 got=%0d exp=1", a_count); end
        step();
        a_ready = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", a_valid); end
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", a_ovf); end
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", a_ovf); end
    endtask

    task automatic test_full_pop_same_edge();
        a_push(8'h44);
        a_ack_exp = ~a_ack_exp;
        a_push(8'h55);
        a_ack_exp = ~a_ack_exp;
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL fp_full got=%0d exp=2", a_count); end
        a_unsync = 8'h66;
        a_en = 1'b1;
        step(); step();
        a_ready = 1'b1;
        step(); // capture and pop on the same edge
        a_ack_exp = ~a_ack_exp;
        a_ready = 1'b0;
        a_en = 1'b0;
        checks++; if (a_pulse !== 1'b1) begin errors++; $display("FAIL fp_pulse got=%b exp=1", a_pulse); end
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL fp_count got=%0d exp=2", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fp_ovf got=%b exp=0", a_ovf); end
        checks++; if (a_bus !== 8'h55) begin errors++; $display("FAIL fp_head got=%h exp=55", a_bus); end
        checks++; if (a_ack !== a_ack_exp) begin errors++; $display("FAIL fp_ack got=%b exp=%b", a_ack, a_ack_exp); end
        step(); step(); step();
        a_ready = 1'b1;
        step();
        checks++; if (a_bus !== 8'h66) begin errors++; $display("FAIL fp_order got=%h exp=66", a_bus); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL fp_count1 got=%0d exp=1", a_count); end
        step();
        a_ready = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL fp_drained got=%b exp=0", a_valid); end
    endtask

    task automatic test_empty_push_pop();
        a_ready = 1'b1;
        a_unsync = 8'h77;
        a_en = 1'b1;
        step(); step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL ep_pre_valid got=%b exp=0", a_valid); end
        step();
        a_ack_exp = ~a_ack_exp;
        a_en = 1'b0;
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL ep_count got=%0d exp=1", a_count); end
        checks++; if (a_bus !== 8'h77) begin errors++; $display("FAIL ep_bus got=%h exp=77", a_bus); end
        checks++; if (a_ack !== a_ack_exp) begin errors++; $display("FAIL ep_ack got=%b exp=%b", a_ack, a_ack_exp); end
        step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL ep_popped got=%b exp=0", a_valid); end
        a_ready = 1'b0;
        step(); step();
    endtask

    task automatic test_toggle();
        int pulses;
        b_unsync = 8'h3C;
        b_en = 1'b1;
        step(); step(); step(); // E0..E2
        checks++; if (b_pulse !== 1'b0) begin errors++; $display("FAIL tg_early_pulse got=%b exp=0", b_pulse); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL tg_early_valid got=%b exp=0", b_valid); end
        step(); // E3
        checks++; if (b_pulse !== 1'b1) begin errors++; $display("FAIL tg_pulse1 got=%b exp=1", b_pulse); end
        checks++; if (b_bus !== 8'h3C) begin errors++; $display("FAIL tg_bus1 got=%h exp=3c", b_bus); end
        checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL tg_ack1 got=%b exp=1", b_ack); end
        step();
        b_unsync = 8'hC3;
        b_en = 1'b0;
        step(); step(); step();
        checks++; if (b_count !== 2'd1) begin errors++; $display("FAIL tg_count_mid got=%0d exp=1", b_count); end
        step();
        checks++; if (b_pulse !== 1'b1) begin errors++; $display("FAIL tg_pulse2 got=%b exp=1", b_pulse); end
        checks++; if (b_count !== 2'd2) begin errors++; $display("FAIL tg_count2 got=%0d exp=2", b_count); end
        checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL tg_ack2 got=%b exp=0", b_ack); end
        checks++; if (b_bus !== 8'h3C) begin errors++; $display("FAIL tg_head got=%h exp=3c", b_bus); end
        b_ready = 1'b1;
        step();
        checks++; if (b_bus !== 8'hC3) begin errors++; $display("FAIL tg_second got=%h exp=c3", b_bus); end
        step();
        b_ready = 1'b0;
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL tg_drained got=%b exp=0", b_valid); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (b_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL tg_extra_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        a_push(8'h81);
        a_push(8'h82);
        a_push(8'h83);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL rm_pre_count got=%0d exp=1", a_count); end
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL rm_pre_ovf got=%b exp=1", a_ovf); end
        a_unsync = 8'h99;
        a_en = 1'b1;
        dest_rst = 1'b1;
        #2;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", a_valid); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL rm_count got=%0d exp=0", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL rm_ovf got=%b exp=0", a_ovf); end
        checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL rm_ack got=%b exp=0", a_ack); end
        checks++; if (a_bus !== 8'h00) begin errors++; $display("FAIL rm_bus got=%h exp=00", a_bus); end
        checks++; if (a_pulse !== 1'b0) begin errors++; $display("FAIL rm_pulse got=%b exp=0", a_pulse); end
        step(); step();
        dest_rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL rm_events got=%0d exp=1", pulses); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL rm_post_count got=%0d exp=1", a_count); end
        checks++; if (a_bus !== 8'h99) begin errors++; $display("FAIL rm_post_bus got=%h exp=99", a_bus); end
        checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL rm_post_ack got=%b exp=1", a_ack); end
        a_en = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_random();
        logic        m_s0 = 1'b0, m_s1 = 1'b0, m_sd = 1'b0;
        logic        m_ovf = 1'b0, m_ack = 1'b0;
        logic        ev, full, pop;
        logic [15:0] q[$];
        int          drops = 0, delivered = 0, qs, rate;
        for (int e = 0; e < 200; e++) begin
            rate = (e < 100) ? 20 : 60;
            for (int k = 0; k < 5; k++) begin
                if (k == 0) begin
                    c_unsync = 16'($urandom);
                    c_en = 1'b1;
                end
                if (k == 2) c_en = 1'b0;
                c_ready = ($urandom_range(0, 99) < rate);
                c_clr   = ($urandom_range(0, 99) < 5);
                ev   = m_s1 & ~m_sd;
                full = (q.size() == 4);
                pop  = (q.size() != 0) && c_ready;
                if (pop) begin
                    void'(q.pop_front());
                    delivered++;
                end
                if (ev && (!full || pop)) begin
                    q.push_back(c_unsync);
                    m_ack = ~m_ack;
                end else if (ev) begin
                    drops++;
                end
                if (ev && full && !pop) m_ovf = 1'b1;
                else if (c_clr) m_ovf = 1'b0;
                m_sd = m_s1;
                m_s1 = m_s0;
                m_s0 = c_en;
                step();
                qs = q.size();
                checks++; if (c_count !== qs[2:0]) begin errors++; $display("FAIL rnd_count ev=%0d got=%0d exp=%0d", e, c_count, qs); end
                checks++; if (c_valid !== (qs != 0)) begin errors++; $display("FAIL rnd_valid ev=%0d got=%b exp=%b", e, c_valid, qs != 0); end
                if (qs != 0) begin
                    checks++; if (c_bus !== q[0]) begin errors++; $display("FAIL rnd_head ev=%0d got=%h exp=%h", e, c_bus, q[0]); end
                end
                checks++; if (c_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf ev=%0d got=%b exp=%b", e, c_ovf, m_ovf); end
                checks++; if (c_ack !== m_ack) begin errors++; $display("FAIL rnd_ack ev=%0d got=%b exp=%b", e, c_ack, m_ack); end
                checks++; if (c_pulse !== ev) begin errors++; $display("FAIL rnd_pulse ev=%0d got=%b exp=%b", e, c_pulse, ev); end
            end
        end
        c_ready = 1'b0;
        c_clr = 1'b0;
        checks++; if (delivered + drops + q.size() != 200) begin errors++; $display("FAIL rnd_accounting got=%0d exp=200", delivered + drops + q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_overflow();
        test_full_pop_same_edge();
        test_empty_push_pop();
        test_toggle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
